// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with registered rise/fall strobes.
// Optional coincident-phase pulse on aligned_stb when CLKDIV_ALIGN_STB_EN is defined.
module clk_div_multi #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    resync,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic [NUM_CH*CNT_W-1:0] high_i,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       rise_stb,
  output logic [NUM_CH-1:0]       fall_stb,
  output logic                    aligned_stb
);

  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] ps_q  [NUM_CH];
  logic [CNT_W-1:0] hs_q  [NUM_CH];
  logic [CNT_W-1:0] p_ld  [NUM_CH];
  logic [CNT_W-1:0] h_ld  [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] cnt_zero;
  logic              restart;

  assign restart = !reset || resync;

  // Clamped shadow load values and per-channel counter next-state
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      p_ld[c] = div_i[c*CNT_W +: CNT_W];
      if (p_ld[c] < CNT_W'(2)) p_ld[c] = CNT_W'(2);
      h_ld[c] = high_i[c*CNT_W +: CNT_W];
      if (h_ld[c] == '0) begin
        h_ld[c] = CNT_W'(1);
      end else if (h_ld[c] > p_ld[c] - CNT_W'(1)) begin
        h_ld[c] = p_ld[c] - CNT_W'(1);
      end
      wrap[c]     = (cnt_q[c] == ps_q[c] - CNT_W'(1));
      cnt_zero[c] = (cnt_q[c] == '0);
      cnt_d[c]    = wrap[c] ? '0 : cnt_q[c] + CNT_W'(1);
    end
  end

  // Shadows only reload on restart or at the wrap edge, so periods never get cut short
  always_ff @(posedge clk) begin
    if (restart) begin
      clk_out  <= '0;
      rise_stb <= '0;
      fall_stb <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        ps_q[c]  <= p_ld[c];
        hs_q[c]  <= h_ld[c];
      end
    end else if (run) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        clk_out[c]  <= (cnt_q[c] < hs_q[c]);
        rise_stb[c] <= cnt_zero[c];
        fall_stb[c] <= (cnt_q[c] == hs_q[c]);
        cnt_q[c]    <= cnt_d[c];
        if (wrap[c]) begin
          ps_q[c] <= p_ld[c];
          hs_q[c] <= h_ld[c];
        end
      end
    end else begin
      rise_stb <= '0;
      fall_stb <= '0;
    end
  end

`ifdef CLKDIV_ALIGN_STB_EN
  // All channels at phase 0 on a running edge
  always_ff @(posedge clk) begin
    if (restart) begin
      aligned_stb <= 1'b0;
    end else begin
      aligned_stb <= run && (&cnt_zero);
    end
  end
`else
  assign aligned_stb = 1'b0;
`endif

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider. Generates NUM_CH divided clock-phase outputs from one master clock, plus registered rise/fall strobes per channel.
- Each channel has a runtime-programmable period and high time. Values are loaded at period boundaries, so divisor changes never glitch.
- Sits at the top of the clock tree. Feeds CPU/PPU/APU enables (e.g. ÷12 and ÷4 of master) and any future derived rates.

Parameters:
- NUM_CH, 2, number of output channels (1..8)
- CNT_W, 4, width of per-channel counter and of each divisor/high-time field

Ports:
- clk  input  1  master clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge
- run  input  1  1 = channels advance; 0 = freeze all channels
- resync  input  1  1 = restart all channels at phase 0 (phase alignment)
- div_i  input  NUM_CH*CNT_W  per-channel period P in cycles; channel c in bits [c*CNT_W +: CNT_W]
- high_i  input  NUM_CH*CNT_W  per-channel high time H in cycles; same packing
- clk_out  output  NUM_CH  registered divided clocks
- rise_stb  output  NUM_CH  1-cycle pulse, coincident with the cycle clk_out[c] first reads 1
- fall_stb  output  NUM_CH  1-cycle pulse, coincident with the cycle clk_out[c] first reads 0
- aligned_stb  output  1  see Optional Feature

Behaviour:
- Per channel: counter cnt[c], shadow period Ps[c], shadow high Hs[c].
- Clamping, applied when loading shadows:
  - P = max(div_i, 2).
  - H = high_i clamped to the range 1..P-1.
- Priority per edge: reset low > resync > run.
- reset low:
  - cnt = 0; clk_out = 0; rise_stb = 0; fall_stb = 0; aligned_stb = 0.
  - Shadows load the clamped div_i/high_i.
- resync = 1 (reset high), regardless of run:
  - Same register effect as reset: cnt = 0, outputs 0, shadows reload.
  - All channels restart together.
- run = 1, normal edge, each channel:
  - clk_out <= (cnt < Hs).
  - rise_stb <= (cnt == 0).
  - fall_stb <= (cnt == Hs).
  - If cnt == Ps-1: cnt <= 0 and shadows reload the clamped inputs. Otherwise cnt <= cnt+1.
- Resulting waveform and latency:
  - Outputs lag the counter by one edge.
  - clk_out is high for exactly Hs cycles and low for Ps-Hs cycles.
  - The first edge after reset/resync release drives clk_out high and rise_stb = 1.
- run = 0:
  - cnt, shadows and clk_out hold.
  - rise_stb, fall_stb and aligned_stb are forced to 0 on that edge.
  - On resume, the counter continues from the held value; no phase loss.
- Divisor/high changes mid-period are ignored until the wrap edge. The current period always completes with the old values.
- Counter wrap is bounded by Ps-1 ≤ 2^CNT_W-1; no arithmetic overflow possible.
- div_i/high_i are sampled only at reset, resync and wrap edges. Upstream holds them stable or accepts period-boundary update.

Optional Feature:
- Macro CLKDIV_ALIGN_STB_EN.
- Defined: aligned_stb <= 1 on an edge where run = 1 and every channel has cnt == 0. This is a coincident-phase pulse, registered the same as rise_stb. Otherwise 0.
- Not defined: aligned_stb tied to constant 0; no comparison logic synthesised.

Test Plan:
- NUM_CH=2, CNT_W=4, div={4,12}, high={2,6}, reset low 3 cycles then high, run=1:
  - ch0 (÷12): 6 high / 6 low.
  - ch1 (÷4): 2 high / 2 low.
  - Both rise_stb at first edge after release.
  - fall_stb at 7th and 3rd edge respectively.
- ch1 div changed 4->8 (high 2->4) while cnt[1]=1 -> current period still 4 cycles; next period 8 cycles with 4 high. No runt pulse.
- run=0 for 5 cycles with cnt[0]=3:
  - clk_out frozen; all strobes 0.
  - After run=1, ch0 output stays high 3 more cycles, then falls.
- Clamp: div=0, high=0 -> period 2, high 1. div=4, high=9 -> period 4, high 3. div=5, high=5 -> high 4.
- resync pulse mid-period (cnt0=7, cnt1=2) -> next edge both clk_out=0; following edge both rise together with rise_stb=2'b11. Repeat with reset low mid-period -> identical result.
- With CLKDIV_ALIGN_STB_EN, div={4,12} -> aligned_stb pulses every 12 cycles, coincident with ch0 rise_stb. Without macro -> aligned_stb constantly 0.
